// File: rtl/sudoku_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sudoku_pkg
// Description : Shared constants and controller state encoding for the
//               Sudoku constraint-propagation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sudoku_pkg;

  localparam int unsigned SUDOKU_CELLS = 81;
  localparam int unsigned SUDOKU_VAL_W = 4;
  localparam int unsigned SUDOKU_IDX_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PAD   = 3'd2,
    ST_CHECK = 3'd3,
    ST_STEP  = 3'd4,
    ST_EVAL  = 3'd5,
    ST_OUT   = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sudoku_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : sudoku_stream_out
// Description : Result streamer. A start pulse sweeps the engine read address
//               over all cells; each read is registered onto the output beat
//               together with the pass/fail flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sudoku_stream_out
  import sudoku_pkg::*;
#(
  parameter int unsigned CELLS = SUDOKU_CELLS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    fail_i,
  input  logic [SUDOKU_VAL_W-1:0] rd_data_i,
  output logic [SUDOKU_IDX_W-1:0] rd_idx_o,
  output logic                    out_valid_o,
  output logic [SUDOKU_VAL_W-1:0] out_o,
  output logic                    out_fail_o,
  output logic                    done_o
);

  localparam logic [SUDOKU_IDX_W-1:0] LAST_IDX = SUDOKU_IDX_W'(CELLS - 1);

  logic                    active_q, active_d;
  logic [SUDOKU_IDX_W-1:0] idx_q, idx_d;
  logic                    valid_q, valid_d;
  logic [SUDOKU_VAL_W-1:0] data_q, data_d;
  logic                    fail_q, fail_d;

  // Address sweep (saturates on the last cell) and output beat capture.
  always_comb begin
    active_d = active_q;
    idx_d    = idx_q;
    valid_d  = active_q;
    data_d   = active_q ? rd_data_i : '0;
    fail_d   = active_q ? fail_i : 1'b0;
    if (start_i) begin
      active_d = 1'b1;
      idx_d    = '0;
    end else if (active_q) begin
      if (idx_q == LAST_IDX) begin
        active_d = 1'b0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Streamer registers; reset truncates any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      fail_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      fail_q   <= fail_d;
    end
  end

  assign rd_idx_o    = idx_q;
  assign out_valid_o = valid_q;
  assign out_o       = data_q;
  assign out_fail_o  = fail_q;
  // The last beat is on the output once reads have stopped but valid is high.
  assign done_o      = valid_q & ~active_q;

endmodule
`default_nettype wire

// File: rtl/sudoku_solve_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sudoku_solve_ctrl
// Description : Sequencer for the Sudoku propagation engine: loads a puzzle
//               stream (padding short puzzles with empties), issues
//               propagation steps until solved/stuck/over budget, then
//               streams the grid back with a fail flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sudoku_solve_ctrl
  import sudoku_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 255,
  parameter int unsigned CELLS     = SUDOKU_CELLS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid_i,
  input  logic [SUDOKU_VAL_W-1:0] in_i,
  output logic                    out_valid_o,
  output logic [SUDOKU_VAL_W-1:0] out_o,
  output logic                    out_fail_o,
  output logic                    busy_o,
  output logic                    eng_clear_o,
  output logic                    eng_load_en_o,
  output logic [SUDOKU_VAL_W-1:0] eng_load_data_o,
  output logic                    eng_step_o,
  input  logic                    eng_solved_i,
  input  logic                    eng_progress_i,
  output logic [SUDOKU_IDX_W-1:0] eng_rd_idx_o,
  input  logic [SUDOKU_VAL_W-1:0] eng_rd_data_i
);

  localparam logic [SUDOKU_IDX_W-1:0] LOAD_LAST  = SUDOKU_IDX_W'(CELLS);
  localparam logic [7:0]              STEP_LIMIT = 8'(MAX_STEPS);

  state_e                  state_q, state_d;
  logic [SUDOKU_IDX_W-1:0] load_cnt_q, load_cnt_d;
  logic [7:0]              step_cnt_q, step_cnt_d;
  logic                    fail_q, fail_d;
  logic                    load_en_q, load_en_d;
  logic [SUDOKU_VAL_W-1:0] load_data_q, load_data_d;
  logic                    out_start;
  logic                    stream_done;

  // Next-state, load staging, step pulse and stream start decode.
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    step_cnt_d  = step_cnt_q;
    fail_d      = fail_q;
    load_en_d   = 1'b0;
    load_data_d = '0;
    out_start   = 1'b0;
    eng_step_o  = 1'b0;
    eng_clear_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        eng_clear_o = 1'b1;
        if (in_valid_i) begin
          state_d     = ST_LOAD;
          load_cnt_d  = SUDOKU_IDX_W'(1);
          load_en_d   = 1'b1;
          load_data_d = in_i;
        end
      end
      ST_LOAD: begin
        if (load_cnt_q == LOAD_LAST) begin
          state_d = ST_CHECK;
        end else if (in_valid_i) begin
          load_cnt_d  = load_cnt_q + 1'b1;
          load_en_d   = 1'b1;
          load_data_d = in_i;
        end else begin
          state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        if (load_cnt_q == LOAD_LAST) begin
          state_d = ST_CHECK;
        end else begin
          load_cnt_d = load_cnt_q + 1'b1;
          load_en_d  = 1'b1;
        end
      end
      ST_CHECK: begin
        if (eng_solved_i) begin
          state_d   = ST_OUT;
          fail_d    = 1'b0;
          out_start = 1'b1;
        end else begin
          step_cnt_d = '0;
          state_d    = ST_STEP;
        end
      end
      ST_STEP: begin
        eng_step_o = 1'b1;
        step_cnt_d = step_cnt_q + 1'b1;
        state_d    = ST_EVAL;
      end
      ST_EVAL: begin
        // Solved wins over stuck and budget exhaustion.
        if (eng_solved_i) begin
          state_d   = ST_OUT;
          fail_d    = 1'b0;
          out_start = 1'b1;
        end else if (!eng_progress_i || (step_cnt_q == STEP_LIMIT)) begin
          state_d   = ST_OUT;
          fail_d    = 1'b1;
          out_start = 1'b1;
        end else begin
          state_d = ST_STEP;
        end
      end
      ST_OUT: begin
        if (stream_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller state and registered engine load port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      load_cnt_q  <= '0;
      step_cnt_q  <= '0;
      fail_q      <= 1'b0;
      load_en_q   <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      step_cnt_q  <= step_cnt_d;
      fail_q      <= fail_d;
      load_en_q   <= load_en_d;
      load_data_q <= load_data_d;
    end
  end

  assign busy_o          = (state_q != ST_IDLE);
  assign eng_load_en_o   = load_en_q;
  assign eng_load_data_o = load_data_q;

  sudoku_stream_out #(
    .CELLS (CELLS)
  ) u_stream_out (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (out_start),
    .fail_i      (fail_q),
    .rd_data_i   (eng_rd_data_i),
    .rd_idx_o    (eng_rd_idx_o),
    .out_valid_o (out_valid_o),
    .out_o       (out_o),
    .out_fail_o  (out_fail_o),
    .done_o      (stream_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_sudoku_solve_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sudoku_solve_ctrl
// Description : Self-checking bench for sudoku_solve_ctrl with a behavioural
//               engine model and an output-beat scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sudoku_solve_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_valid;
  logic [3:0] out_val;
  logic       out_fail;
  logic       busy;
  logic       eng_clear;
  logic       eng_load_en;
  logic [3:0] eng_load_data;
  logic       eng_step;
  logic       eng_solved;
  logic       eng_progress;
  logic [6:0] eng_rd_idx;
  logic [3:0] eng_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  // Engine model state
  logic [3:0] map [81];
  logic [3:0] sol [81];
  logic [3:0] pz  [81];
  bit         fill_mode = 1'b0;
  int         stuck_at  = 1000;
  int         step_no   = 0;
  int         step_pulses = 0;
  int         load_pulses = 0;
  int         zero_loads  = 0;

  // Scoreboard
  int mon_exp_q[$];
  bit mon_fail_q[$];
  int mon_e;
  bit mon_f;

  sudoku_solve_ctrl #(
    .MAX_STEPS (4),
    .CELLS     (81)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid_i      (in_valid),
    .in_i            (in_data),
    .out_valid_o     (out_valid),
    .out_o           (out_val),
    .out_fail_o      (out_fail),
    .busy_o          (busy),
    .eng_clear_o     (eng_clear),
    .eng_load_en_o   (eng_load_en),
    .eng_load_data_o (eng_load_data),
    .eng_step_o      (eng_step),
    .eng_solved_i    (eng_solved),
    .eng_progress_i  (eng_progress),
    .eng_rd_idx_o    (eng_rd_idx),
    .eng_rd_data_i   (eng_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Engine model: solved when no cell is empty.
  always_comb begin
    eng_solved = 1'b1;
    for (int i = 0; i < 81; i++) begin
      if (map[i] == 4'd0) eng_solved = 1'b0;
    end
  end

  assign eng_rd_data = (eng_rd_idx < 7'd81) ? map[eng_rd_idx] : 4'd0;

  // Engine model: shift load, clear, propagation step.
  always @(posedge clk) begin
    if (eng_load_en) begin
      for (int i = 0; i < 80; i++) map[i] <= map[i+1];
      map[80] <= eng_load_data;
    end else if (eng_clear) begin
      for (int i = 0; i < 81; i++) map[i] <= 4'd0;
    end else if (eng_step && fill_mode) begin
      for (int i = 0; i < 81; i++) if (map[i] == 4'd0) map[i] <= sol[i];
    end
    if (eng_clear) begin
      step_no <= 0;
    end else if (eng_step) begin
      step_no      <= step_no + 1;
      eng_progress <= fill_mode ? !eng_solved : ((step_no + 1) < stuck_at);
    end
  end

  // Engine-port event counters
  always @(posedge clk) begin
    if (eng_step) step_pulses <= step_pulses + 1;
    if (eng_load_en) begin
      load_pulses <= load_pulses + 1;
      if (eng_load_data == 4'd0) zero_loads <= zero_loads + 1;
    end
  end

  // Output monitor against the scoreboard queue
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (mon_exp_q.size() == 0) begin
        check_eq("extra_beat", {31'd0, out_valid}, 32'd0);
      end else begin
        mon_e = mon_exp_q.pop_front();
        mon_f = mon_fail_q.pop_front();
        check_eq("beat_val", {28'd0, out_val}, mon_e);
        check_eq("beat_fail", {31'd0, out_fail}, {31'd0, mon_f});
      end
    end
  end

  task automatic push_exp(input int n_beats, input bit exp_fail, output int nz);
    int v;
    nz = 0;
    for (int i = 0; i < 81; i++) begin
      v = (i < n_beats) ? int'(pz[i]) : 0;
      if (v == 0) nz++;
      mon_exp_q.push_back(v);
      mon_fail_q.push_back(exp_fail);
    end
  endtask

  task automatic drive_beats(input int n_beats);
    for (int i = 0; i < n_beats; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = pz[i];
      if (i == 1) check_eq("busy_first", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 4'd0;
  endtask

  task automatic run_puzzle(input string name, input int n_beats, input int exp_steps, input bit exp_fail);
    int s0, l0, z0, nz, cyc;
    $display("-- %s", name);
    push_exp(n_beats, exp_fail, nz);
    s0 = step_pulses;
    l0 = load_pulses;
    z0 = zero_loads;
    drive_beats(n_beats);
    cyc = 0;
    while (mon_exp_q.size() != 0 && cyc < 3000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_eq("beats_left", mon_exp_q.size(), 0);
    mon_exp_q.delete();
    mon_fail_q.delete();
    @(negedge clk);
    check_eq("ovalid_after", {31'd0, out_valid}, 32'd0);
    check_eq("busy_after", {31'd0, busy}, 32'd0);
    check_eq("step_pulses", step_pulses - s0, exp_steps);
    check_eq("load_pulses", load_pulses - l0, 81);
    check_eq("zero_loads", zero_loads - z0, nz);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, c, cyc;
    int nz;
    for (int i = 0; i < 81; i++) begin
      r = i / 9;
      c = i % 9;
      sol[i] = 4'(((r * 3 + r / 3 + c + 5) % 9) + 1);
    end
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'd0;
    eng_progress = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out", {28'd0, out_val}, 32'd0);
    check_eq("rst_out_fail", {31'd0, out_fail}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_clear", {31'd0, eng_clear}, 32'd1);
    check_eq("rst_load_en", {31'd0, eng_load_en}, 32'd0);
    check_eq("rst_step", {31'd0, eng_step}, 32'd0);
    check_eq("rst_rd_idx", {25'd0, eng_rd_idx}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // One empty cell (40), filled on the first step
    for (int i = 0; i < 81; i++) pz[i] = sol[i];
    pz[40] = 4'd0;
    fill_mode = 1'b1;
    for (int i = 0; i < 81; i++) pz[i] = pz[i];
    // Expected grid after solving equals the solution
    begin
      logic [3:0] tmp [81];
      for (int i = 0; i < 81; i++) tmp[i] = pz[i];
      for (int i = 0; i < 81; i++) pz[i] = sol[i];
      push_exp(81, 1'b0, nz);
      for (int i = 0; i < 81; i++) pz[i] = tmp[i];
    end
    check_eq("sol40", {28'd0, sol[40]}, 32'd5);
    begin
      int s0;
      s0 = step_pulses;
      drive_beats(81);
      cyc = 0;
      while (mon_exp_q.size() != 0 && cyc < 3000) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      check_eq("one_empty_left", mon_exp_q.size(), 0);
      mon_exp_q.delete();
      mon_fail_q.delete();
      @(negedge clk);
      check_eq("one_empty_ovalid_after", {31'd0, out_valid}, 32'd0);
      check_eq("one_empty_steps", step_pulses - s0, 1);
    end

    // Fully given grid: no steps
    for (int i = 0; i < 81; i++) pz[i] = sol[i];
    fill_mode = 1'b0;
    stuck_at  = 1000;
    run_puzzle("full", 81, 0, 1'b0);

    // Stuck on step 3
    for (int i = 0; i < 81; i++) pz[i] = (i % 7 == 0) ? 4'd0 : sol[i];
    stuck_at = 3;
    run_puzzle("stuck3", 81, 3, 1'b1);

    // Budget (MAX_STEPS=4): always progresses, never solves
    stuck_at = 1000;
    run_puzzle("budget", 81, 4, 1'b1);

    // Short puzzle, 70 beats, padded with empties; stuck on step 1
    for (int i = 0; i < 81; i++) pz[i] = sol[i];
    stuck_at = 1;
    run_puzzle("short70", 70, 1, 1'b1);

    // Reset during output beat 30
    for (int i = 0; i < 81; i++) pz[i] = (i % 7 == 0) ? 4'd0 : sol[i];
    stuck_at = 1000;
    push_exp(81, 1'b1, nz);
    drive_beats(81);
    cyc = 0;
    while (mon_exp_q.size() > 51 && cyc < 3000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_eq("rst_wait_beats", mon_exp_q.size(), 51);
    @(posedge clk);
    #1;
    check_eq("mid_beat30_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_out_fail", {31'd0, out_fail}, 32'd0);
    check_eq("mid_rst_rd_idx", {25'd0, eng_rd_idx}, 32'd0);
    mon_exp_q.delete();
    mon_fail_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    // Next puzzle after reset loads normally
    for (int i = 0; i < 81; i++) pz[i] = sol[i];
    run_puzzle("after_reset", 81, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
